// File: rtl/vector_commit_tracker_pkg.sv
// vector_commit_tracker_pkg: shared constants and types for the vector commit tracker.
package vector_commit_tracker_pkg;
   localparam int VCT_NUM_LANES = 16;
   localparam int VCT_DEPTH     = 4;
   localparam int VCT_TID_W     = 8;
   localparam int VCT_CMD_W     = 32;
   localparam int VCT_TAG_W     = $clog2(VCT_DEPTH);
   typedef logic [VCT_NUM_LANES-1:0] lane_mask_t;
   typedef logic [VCT_TAG_W-1:0] tag_t;
   typedef struct packed {
      logic                 valid;
      lane_mask_t           pending;
      logic [VCT_TID_W-1:0] tid;
   } commit_entry_t;
endpackage

// File: rtl/vector_commit_entry.sv
// vector_commit_entry: one outstanding command slot holding its pending-lane mask and thread-ID.
module vector_commit_entry
   import vector_commit_tracker_pkg::*;
#(
   parameter int NUM_LANES = VCT_NUM_LANES,
   parameter int TID_W     = VCT_TID_W
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 alloc_i,
   input  logic                 pop_i,
   input  logic [NUM_LANES-1:0] mask_i,
   input  logic [TID_W-1:0]     tid_i,
   input  logic [NUM_LANES-1:0] clr_i,
   output logic                 valid_o,
   output logic [NUM_LANES-1:0] pending_o,
   output logic [TID_W-1:0]     tid_o,
   output logic                 complete_o
);
   logic                 valid_q, valid_d;
   logic [NUM_LANES-1:0] pending_q, pending_d;
   logic [TID_W-1:0]     tid_q, tid_d;
   always_comb begin
      valid_d   = alloc_i | (valid_q & ~pop_i);
      pending_d = alloc_i ? mask_i : pending_q & ~clr_i;
      tid_d     = alloc_i ? tid_i : tid_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q   <= 1'b0;
         pending_q <= '0;
         tid_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         pending_q <= pending_d;
         tid_q     <= tid_d;
      end
   end
   assign valid_o    = valid_q;
   assign pending_o  = pending_q;
   assign tid_o      = tid_q;
   assign complete_o = valid_q & ~|pending_q;
endmodule

// File: rtl/vector_commit_tracker.sv
// vector_commit_tracker: tags and broadcasts vector commands, collects per-lane completions
// and raises in-order commit requests.
module vector_commit_tracker
   import vector_commit_tracker_pkg::*;
#(
   parameter int NUM_LANES = VCT_NUM_LANES,
   parameter int DEPTH     = VCT_DEPTH,
   parameter int TID_W     = VCT_TID_W,
   parameter int CMD_W     = VCT_CMD_W,
   localparam int TAG_W    = $clog2(DEPTH),
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       I_Issue_Valid,
   output logic                       O_Issue_Ready,
   input  logic [NUM_LANES-1:0]       I_En_Lane,
   input  logic [TID_W-1:0]           I_ThreadID,
   input  logic [CMD_W-1:0]           I_Command,
   output logic                       O_Lane_Valid,
   output logic [NUM_LANES-1:0]       O_En_Lane,
   output logic [TID_W-1:0]           O_ThreadID,
   output logic [CMD_W-1:0]           O_Command,
   output logic [TAG_W-1:0]           O_Tag,
   input  logic [NUM_LANES-1:0]       I_Lane_Commit,
   input  logic [NUM_LANES*TAG_W-1:0] I_Lane_Commit_Tag,
   output logic                       O_Commit_Req,
   output logic [TID_W-1:0]           O_Commit_ThreadID,
   output logic [TAG_W-1:0]           O_Commit_Tag,
   input  logic                       I_Commit_Ack,
   output logic [NUM_LANES-1:0]       O_Status,
   output logic [CNT_W-1:0]           O_Count,
   output logic                       O_Err
);
   logic [TAG_W-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]                  count_q, count_d;
   logic                              err_q, err_d;
   logic                              lane_valid_q;
   logic [NUM_LANES-1:0]              en_q;
   logic [TID_W-1:0]                  tid_q;
   logic [CMD_W-1:0]                  cmd_q;
   logic [TAG_W-1:0]                  tag_q;
   logic                              accept, pop;
   logic [DEPTH-1:0]                  valid, complete, alloc, pop_e;
   logic [DEPTH-1:0][NUM_LANES-1:0]   pending, clr;
   logic [DEPTH-1:0][TID_W-1:0]       tid;
   logic [NUM_LANES-1:0]              hit, status;
   assign O_Issue_Ready = count_q < CNT_W'(DEPTH);
   assign accept        = I_Issue_Valid & O_Issue_Ready;
   assign O_Commit_Req  = complete[rd_ptr_q];
   assign pop           = I_Commit_Ack & O_Commit_Req;
   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_entry
         assign alloc[g] = accept && wr_ptr_q == TAG_W'(g);
         assign pop_e[g] = pop && rd_ptr_q == TAG_W'(g);
         vector_commit_entry #(.NUM_LANES(NUM_LANES), .TID_W(TID_W)) u_entry (
            .clock      (clock),
            .reset      (reset),
            .alloc_i    (alloc[g]),
            .pop_i      (pop_e[g]),
            .mask_i     (I_En_Lane),
            .tid_i      (I_ThreadID),
            .clr_i      (clr[g]),
            .valid_o    (valid[g]),
            .pending_o  (pending[g]),
            .tid_o      (tid[g]),
            .complete_o (complete[g])
         );
      end
   endgenerate
   // A lane pulse that clears nothing (stale tag, invalid entry, bit already clear) is a protocol error.
   always_comb begin
      wr_ptr_d = wr_ptr_q + TAG_W'(accept);
      rd_ptr_d = rd_ptr_q + TAG_W'(pop);
      count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);
      clr      = '0;
      hit      = '0;
      status   = '0;
      for (int e = 0; e < DEPTH; e++) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            clr[e][i] = I_Lane_Commit[i] && I_Lane_Commit_Tag[i*TAG_W +: TAG_W] == TAG_W'(e)
                        && valid[e] && pending[e][i];
            hit[i]    = hit[i] | clr[e][i];
         end
         status = status | (valid[e] ? pending[e] : '0);
      end
      err_d = err_q | |(I_Lane_Commit & ~hit);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
         lane_valid_q <= 1'b0;
         en_q         <= '0;
         tid_q        <= '0;
         cmd_q        <= '0;
         tag_q        <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         err_q        <= err_d;
         lane_valid_q <= accept;
         if (accept) begin
            en_q  <= I_En_Lane;
            tid_q <= I_ThreadID;
            cmd_q <= I_Command;
            tag_q <= wr_ptr_q;
         end
      end
   end
   assign O_Lane_Valid      = lane_valid_q;
   assign O_En_Lane         = en_q;
   assign O_ThreadID        = tid_q;
   assign O_Command         = cmd_q;
   assign O_Tag             = tag_q;
   assign O_Commit_ThreadID = tid[rd_ptr_q];
   assign O_Commit_Tag      = rd_ptr_q;
   assign O_Status          = status;
   assign O_Count           = count_q;
   assign O_Err             = err_q;
endmodule

// File: tb/tb_vector_commit_tracker.sv
// tb_vector_commit_tracker: directed table, corner sequences and a queue-based random reference check.
module tb_vector_commit_tracker;
   localparam int NL = 4, D = 4, TW = 8, CW = 32, TGW = 2, CNW = 3;
   logic            clock = 1'b0, reset;
   logic            iv, ack, ready, lv, req, err;
   logic [NL-1:0]   mask, cm, o_en, st;
   logic [TW-1:0]   itid, o_tid, c_tid;
   logic [CW-1:0]   cmd, o_cmd;
   logic [NL*TGW-1:0] ct;
   logic [TGW-1:0]  o_tag, c_tag;
   logic [CNW-1:0]  cnt;
   int errors = 0, checks = 0;

   vector_commit_tracker #(.NUM_LANES(NL), .DEPTH(D), .TID_W(TW), .CMD_W(CW)) dut (
      .clock(clock), .reset(reset), .I_Issue_Valid(iv), .O_Issue_Ready(ready),
      .I_En_Lane(mask), .I_ThreadID(itid), .I_Command(cmd), .O_Lane_Valid(lv),
      .O_En_Lane(o_en), .O_ThreadID(o_tid), .O_Command(o_cmd), .O_Tag(o_tag),
      .I_Lane_Commit(cm), .I_Lane_Commit_Tag(ct), .O_Commit_Req(req),
      .O_Commit_ThreadID(c_tid), .O_Commit_Tag(c_tag), .I_Commit_Ack(ack),
      .O_Status(st), .O_Count(cnt), .O_Err(err));

   always #5 clock = ~clock;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", n, a, e);
      end
   endtask

   task automatic drive(input logic v, input logic [NL-1:0] m, input logic [TW-1:0] t,
                        input logic [NL-1:0] c, input logic [NL*TGW-1:0] tg, input logic a);
      iv = v; mask = m; itid = t; cm = c; ct = tg; ack = a; cmd = $urandom;
   endtask

   task automatic step(input logic v, input logic [NL-1:0] m, input logic [TW-1:0] t,
                       input logic [NL-1:0] c, input logic [NL*TGW-1:0] tg, input logic a);
      @(negedge clock);
      drive(v, m, t, c, tg, a);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic v; logic [NL-1:0] m; logic [TW-1:0] t; logic [NL-1:0] c; logic [NL*TGW-1:0] tg; logic a;
      logic e_lv; logic [TGW-1:0] e_tag; logic e_req; logic [TW-1:0] e_ctid;
      logic [CNW-1:0] e_cnt; logic [NL-1:0] e_st; logic e_err;
   } vec_t;
   vec_t tbl[13];

   typedef struct { logic [TGW-1:0] tag; logic [TW-1:0] tid; logic [NL-1:0] pend; } ment_t;
   ment_t q[$];
   logic [TGW-1:0] m_wr;
   logic m_err, b_lv;
   logic [NL-1:0] b_en;
   logic [TW-1:0] b_tid;
   logic [CW-1:0] b_cmd;
   logic [TGW-1:0] b_tag;

   task automatic model_clear();
      q = {}; m_wr = '0; m_err = 1'b0; b_lv = 1'b0; b_en = '0; b_tid = '0; b_cmd = '0; b_tag = '0;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      //               v     mask     tid    commit   tags          ack  | lv   tag   req   ctid   cnt   status   err
      tbl[0]  = '{1'b1, 4'b1011, 8'd5, 4'b0000, 8'b00000000, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 3'd1, 4'b1011, 1'b0};
      tbl[1]  = '{1'b0, 4'b0000, 8'd0, 4'b0011, 8'b00000000, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 3'd1, 4'b1000, 1'b0};
      tbl[2]  = '{1'b0, 4'b0000, 8'd0, 4'b1000, 8'b00000000, 1'b0, 1'b0, 2'd0, 1'b1, 8'd5, 3'd1, 4'b0000, 1'b0};
      tbl[3]  = '{1'b0, 4'b0000, 8'd0, 4'b0000, 8'b00000000, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 3'd0, 4'b0000, 1'b0};
      tbl[4]  = '{1'b1, 4'b1111, 8'd1, 4'b0000, 8'b00000000, 1'b0, 1'b1, 2'd1, 1'b0, 8'd0, 3'd1, 4'b1111, 1'b0};
      tbl[5]  = '{1'b1, 4'b1111, 8'd2, 4'b0000, 8'b00000000, 1'b0, 1'b1, 2'd2, 1'b0, 8'd0, 3'd2, 4'b1111, 1'b0};
      tbl[6]  = '{1'b0, 4'b0000, 8'd0, 4'b1111, 8'b10101010, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 3'd2, 4'b1111, 1'b0};
      tbl[7]  = '{1'b0, 4'b0000, 8'd0, 4'b1111, 8'b01010101, 1'b0, 1'b0, 2'd0, 1'b1, 8'd1, 3'd2, 4'b0000, 1'b0};
      tbl[8]  = '{1'b0, 4'b0000, 8'd0, 4'b0000, 8'b00000000, 1'b1, 1'b0, 2'd0, 1'b1, 8'd2, 3'd1, 4'b0000, 1'b0};
      tbl[9]  = '{1'b0, 4'b0000, 8'd0, 4'b0000, 8'b00000000, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 3'd0, 4'b0000, 1'b0};
      tbl[10] = '{1'b1, 4'b0000, 8'd9, 4'b0000, 8'b00000000, 1'b0, 1'b1, 2'd3, 1'b1, 8'd9, 3'd1, 4'b0000, 1'b0};
      tbl[11] = '{1'b0, 4'b0000, 8'd0, 4'b0000, 8'b00000000, 1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 3'd0, 4'b0000, 1'b0};
      tbl[12] = '{1'b0, 4'b0000, 8'd0, 4'b0100, 8'b00110000, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 3'd0, 4'b0000, 1'b1};

      do_reset();
      chk("reset_ready", ready, 1'b1);
      chk("reset_count", cnt, 3'd0);
      chk("reset_req", req, 1'b0);
      chk("reset_err", err, 1'b0);
      chk("reset_status", st, 4'b0);
      chk("reset_lane_valid", lv, 1'b0);

      for (int r = 0; r < 13; r++) begin
         logic [CW-1:0] sent;
         @(negedge clock);
         drive(tbl[r].v, tbl[r].m, tbl[r].t, tbl[r].c, tbl[r].tg, tbl[r].a);
         sent = cmd;
         @(posedge clock);
         #1;
         chk($sformatf("row%0d_lane_valid", r), lv, tbl[r].e_lv);
         if (tbl[r].e_lv) begin
            chk($sformatf("row%0d_tag", r), o_tag, tbl[r].e_tag);
            chk($sformatf("row%0d_bcast_tid", r), o_tid, tbl[r].t);
            chk($sformatf("row%0d_bcast_mask", r), o_en, tbl[r].m);
            chk($sformatf("row%0d_bcast_cmd", r), o_cmd, sent);
         end
         chk($sformatf("row%0d_req", r), req, tbl[r].e_req);
         if (tbl[r].e_req) chk($sformatf("row%0d_commit_tid", r), c_tid, tbl[r].e_ctid);
         chk($sformatf("row%0d_count", r), cnt, tbl[r].e_cnt);
         chk($sformatf("row%0d_status", r), st, tbl[r].e_st);
         chk($sformatf("row%0d_err", r), err, tbl[r].e_err);
      end

      // mid-flight reset discards outstanding work and the sticky error
      step(1'b1, 4'b0000, 8'd7, '0, '0, 1'b0);
      step(1'b1, 4'b0011, 8'd8, '0, '0, 1'b0);
      chk("midrst_pre_count", cnt, 3'd2);
      do_reset();
      chk("midrst_count", cnt, 3'd0);
      chk("midrst_err", err, 1'b0);
      chk("midrst_req", req, 1'b0);
      chk("midrst_status", st, 4'b0);
      repeat (2) step(1'b0, '0, '0, '0, '0, 1'b0);
      chk("midrst_no_req_later", req, 1'b0);

      // full / backpressure with a complete head
      step(1'b1, 4'b0000, 8'h10, '0, '0, 1'b0);
      step(1'b1, 4'b1111, 8'h11, '0, '0, 1'b0);
      step(1'b1, 4'b1111, 8'h12, '0, '0, 1'b0);
      step(1'b1, 4'b1111, 8'h13, '0, '0, 1'b0);
      chk("full_count", cnt, 3'd4);
      chk("full_ready", ready, 1'b0);
      chk("full_req", req, 1'b1);
      step(1'b1, 4'b0101, 8'h14, '0, '0, 1'b0);
      chk("held_count", cnt, 3'd4);
      chk("held_lane_valid", lv, 1'b0);
      step(1'b1, 4'b0101, 8'h14, '0, '0, 1'b1);
      chk("pop_count", cnt, 3'd3);
      chk("pop_ready", ready, 1'b1);
      chk("pop_lane_valid", lv, 1'b0);
      step(1'b1, 4'b0101, 8'h14, '0, '0, 1'b0);
      chk("fifth_lane_valid", lv, 1'b1);
      chk("fifth_tag", o_tag, 2'd0);
      chk("fifth_tid", o_tid, 8'h14);
      chk("fifth_count", cnt, 3'd4);
      chk("fifth_req_blocked", req, 1'b0);

      // randomized run against a queue model
      do_reset();
      model_clear();
      for (int c = 0; c < 3000; c++) begin
         logic m_req, acc;
         int sz;
         logic [NL-1:0] e_st;
         @(negedge clock);
         sz = q.size();
         m_req = sz > 0 && q[0].pend == '0;
         e_st = '0;
         foreach (q[k]) e_st = e_st | q[k].pend;
         chk("rnd_ready", ready, sz < D);
         chk("rnd_count", cnt, sz);
         chk("rnd_req", req, m_req);
         chk("rnd_commit_tag", c_tag, sz > 0 ? q[0].tag : m_wr);
         if (m_req) chk("rnd_commit_tid", c_tid, q[0].tid);
         chk("rnd_status", st, e_st);
         chk("rnd_err", err, m_err);
         chk("rnd_lane_valid", lv, b_lv);
         chk("rnd_bcast", {o_en, o_tid, o_cmd, o_tag}, {b_en, b_tid, b_cmd, b_tag});
         if (c == 1500) begin
            drive(1'b0, '0, '0, '0, '0, 1'b0);
            reset = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
            model_clear();
            continue;
         end
         drive($urandom_range(0, 4) < 3, NL'($urandom_range(0, 15)), TW'($urandom), '0, '0,
               $urandom_range(0, 1) == 1);
         for (int i = 0; i < NL; i++) begin
            int cands[$];
            cands = {};
            if ($urandom_range(0, 2) == 0) begin
               foreach (q[k]) if (q[k].pend[i]) cands.push_back(int'(q[k].tag));
               if (cands.size() > 0 && $urandom_range(0, 39) != 0) begin
                  cm[i] = 1'b1;
                  ct[TGW*i +: TGW] = TGW'(cands[$urandom_range(0, cands.size() - 1)]);
               end else if ($urandom_range(0, 9) == 0) begin
                  cm[i] = 1'b1;
                  ct[TGW*i +: TGW] = TGW'($urandom_range(0, 3));
               end
            end
         end
         acc = iv && sz < D;
         for (int i = 0; i < NL; i++) begin
            if (cm[i]) begin
               logic found;
               found = 1'b0;
               foreach (q[k])
                  if (q[k].tag == ct[TGW*i +: TGW] && q[k].pend[i]) begin
                     q[k].pend[i] = 1'b0;
                     found = 1'b1;
                  end
               if (!found) m_err = 1'b1;
            end
         end
         if (ack && m_req) void'(q.pop_front());
         b_lv = acc;
         if (acc) begin
            q.push_back('{m_wr, itid, mask});
            b_en = mask; b_tid = itid; b_cmd = cmd; b_tag = m_wr;
            m_wr = m_wr + 1'b1;
         end
         @(posedge clock);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
